// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: FSM state encoding, baud divisor and vote helpers.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Sample-phase value loaded at the start edge. The edge is seen about two ticks'
  // worth of phase early relative to the vote window, so starting the phase at 2
  // puts the last vote sample on the nominal bit centre.
  localparam int SAMPLE_PHASE0 = 2;

  // Rounded clocks per oversample tick.
  function automatic int calc_div(input longint clk_hz, input longint baud, input longint os);
    longint den;
    den = baud * os;
    return int'((clk_hz + den / 2) / den);
  endfunction

  // Two-of-three majority.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_baud_tick.sv
// Oversample tick generator: free-running 0..DIV-1 counter, tick on DIV-1,
// synchronous restart to 0.
module uart_baud_tick #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Divider counter; a restart realigns the tick phase to the start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_cnt <= '0;
    else if (i_restart || r_cnt == LAST) r_cnt <= '0;
    else                              r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = (r_cnt == LAST) && !i_restart;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_WIDTH data bits LSB first, 1 stop. Majority-voted
// oversampling, start/stop validation and a one-entry valid/ready holding register.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int SYSTEM_CLK_HZ = 100_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int DATA_WIDTH    = 8,
  parameter int OVERSAMPLE    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  busy
);

  localparam int DIV = calc_div(SYSTEM_CLK_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_WIDTH);

  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_A    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_B    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_VOTE = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_INIT = SW'(SAMPLE_PHASE0);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  logic                  r_sync1, r_sync2;
  logic                  w_rxd_s;
  rx_state_e             r_state, w_next;
  logic                  w_restart, w_tick;
  logic [SW-1:0]         r_samp;
  logic                  r_smp_a, r_smp_b;
  logic                  w_vote, w_bit;
  logic [BW-1:0]         r_bit_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  w_word_done, w_frame_bad;

  // Two-FF synchronizer for the asynchronous line, idling high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxd_s = r_sync2;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // Sample phase within the bit; realigned on every start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_samp <= '0;
    else if (w_restart) r_samp <= S_INIT;
    else if (w_tick)    r_samp <= (r_samp == S_LAST) ? '0 : r_samp + 1'b1;
  end

  // Capture the first two of the three vote samples; the third is the live line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_smp_a <= 1'b1;
      r_smp_b <= 1'b1;
    end else if (w_tick) begin
      if (r_samp == S_A) r_smp_a <= w_rxd_s;
      if (r_samp == S_B) r_smp_b <= w_rxd_s;
    end
  end

  assign w_vote = w_tick && (r_samp == S_VOTE);
  assign w_bit  = maj3(r_smp_a, r_smp_b, w_rxd_s);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; the start edge also restarts the tick divider.
  always_comb begin
    w_next    = r_state;
    w_restart = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rxd_s) begin
          w_next    = ST_START;
          w_restart = 1'b1;
        end
      end
      ST_START: if (w_vote) w_next = w_bit ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_vote && r_bit_idx == B_LAST) w_next = ST_STOP;
      ST_STOP:  if (w_vote) w_next = w_bit ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (w_rxd_s) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Data bits arrive LSB first, so shift right from the MSB end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else if (r_state == ST_START && w_vote) begin
      r_bit_idx <= '0;
    end else if (r_state == ST_DATA && w_vote) begin
      r_shift   <= {w_bit, r_shift[DATA_WIDTH-1:1]};
      r_bit_idx <= r_bit_idx + 1'b1;
    end
  end

  assign w_word_done = (r_state == ST_STOP) && w_vote &&  w_bit;
  assign w_frame_bad = (r_state == ST_STOP) && w_vote && !w_bit;

  // Holding register and error pulses; a completing word is dropped only when
  // the old one is still held and not being taken this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout        <= '0;
      dout_valid  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= w_frame_bad;
      overrun_err <= w_word_done && dout_valid && !dout_ready;
      if (w_word_done && (!dout_valid || dout_ready)) begin
        dout       <= r_shift;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

  assign busy = (r_state != ST_IDLE);

endmodule
